// File: rtl/q3_pkg.sv
// q3_pkg: shared constants and types for the Q3 packed-byte format.
//   Q3_DATA_W    payload width carried in bits 6:0 of a packed byte
//   Q3_TAG_BIT   position of the channel tag within a packed byte
//   CH_A / CH_B  tag values selecting channel A / channel B
//   q3_payload_t one payload word
package q3_pkg;

   localparam int unsigned Q3_DATA_W  = 7;
   localparam int unsigned Q3_TAG_BIT = 7;

   localparam logic CH_A = 1'b0;
   localparam logic CH_B = 1'b1;

   typedef logic [Q3_DATA_W-1:0] q3_payload_t;

endpackage

// File: rtl/q3_sync_fifo.sv
// q3_sync_fifo: first-word-fall-through synchronous FIFO.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (priority over clr)
//   clr    synchronous clear of pointers and occupancy
//   push   write din when not full
//   din    write data
//   full   occupancy == DEPTH
//   pop    advance head when not empty
//   dout   head entry, forced to zero while empty
//   empty  occupancy == 0
// DEPTH must be a power of two >= 2 so the pointers wrap by overflow.
module q3_sync_fifo #(
   parameter int unsigned DATA_W = 7,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   output logic              full,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: dout is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push && !rst && !clr) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/q3_stream_unpacker.sv
// q3_stream_unpacker: receive side of the Q3 packed-byte link. Each accepted
// byte is steered by its tag bit (MSB) into the channel A or channel B FIFO;
// both channels are presented as independent FWFT valid/ready streams.
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_data/valid/ready packed byte input handshake
//   flush              synchronous clear of both FIFOs
//   a_data/valid/ready channel A output stream
//   b_data/valid/ready channel B output stream
//   a_cnt, b_cnt       per-channel accepted-byte counters, saturating at 255
//                      (present only when Q3_STATUS_CNT_EN is defined)
module q3_stream_unpacker
   import q3_pkg::*;
#(
   parameter int unsigned DATA_W     = Q3_DATA_W,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W:0]   in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   output logic [DATA_W-1:0] a_data,
   output logic              a_valid,
   input  logic              a_ready,
   output logic [DATA_W-1:0] b_data,
   output logic              b_valid,
   input  logic              b_ready
`ifdef Q3_STATUS_CNT_EN
   ,
   output logic [7:0]        a_cnt,
   output logic [7:0]        b_cnt
`endif
);

   logic full_a, full_b;
   logic empty_a, empty_b;
   logic xfer, push_a, push_b;

   // Ready depends only on FIFO state, never on in_data.
   assign in_ready = !rst && !full_a && !full_b;
   assign xfer     = in_valid && in_ready;
   assign push_a   = xfer && (in_data[DATA_W] == CH_A);
   assign push_b   = xfer && (in_data[DATA_W] == CH_B);
   assign a_valid  = !empty_a;
   assign b_valid  = !empty_b;

   q3_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (push_a),
      .din   (in_data[DATA_W-1:0]),
      .full  (full_a),
      .pop   (a_ready),
      .dout  (a_data),
      .empty (empty_a)
   );

   q3_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (push_b),
      .din   (in_data[DATA_W-1:0]),
      .full  (full_b),
      .pop   (b_ready),
      .dout  (b_data),
      .empty (empty_b)
   );

`ifdef Q3_STATUS_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         a_cnt <= '0;
         b_cnt <= '0;
      end else begin
         if (push_a && (a_cnt != 8'hFF)) a_cnt <= a_cnt + 8'd1;
         if (push_b && (b_cnt != 8'hFF)) b_cnt <= b_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_q3_stream_unpacker.sv
// tb_q3_stream_unpacker: directed self-checking bench for q3_stream_unpacker.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
// Counter checks are compiled in when Q3_STATUS_CNT_EN is defined.
module tb_q3_stream_unpacker;
   import q3_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   q3_payload_t a_data, b_data;
   logic        a_valid, a_ready;
   logic        b_valid, b_ready;
`ifdef Q3_STATUS_CNT_EN
   logic [7:0]  a_cnt, b_cnt;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   q3_stream_unpacker #(.DATA_W(Q3_DATA_W), .FIFO_DEPTH(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .flush    (flush),
      .a_data   (a_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .b_data   (b_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready)
`ifdef Q3_STATUS_CNT_EN
      ,
      .a_cnt    (a_cnt),
      .b_cnt    (b_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; flush = 1'b0;
      a_ready = 1'b0; b_ready = 1'b0;

      // Reset held two cycles with in_valid asserted
      tick(); tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_a_valid",  32'(a_valid),  32'd0);
      check("rst_b_valid",  32'(b_valid),  32'd0);
      check("rst_a_data",   32'(a_data),   32'h0);
      check("rst_b_data",   32'(b_data),   32'h0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("post_rst_a_valid", 32'(a_valid), 32'd0);

      // Steering
      a_ready = 1'b1; b_ready = 1'b1;
      in_valid = 1'b1; in_data = 8'h15;
      tick();
      check("steer_a_valid", 32'(a_valid), 32'd1);
      check("steer_a_data",  32'(a_data),  32'h15);
      check("steer_b_idle",  32'(b_valid), 32'd0);
      in_data = 8'h9A;
      tick();
      check("steer_a_popped", 32'(a_valid), 32'd0);
      check("steer_b_valid",  32'(b_valid), 32'd1);
      check("steer_b_data",   32'(b_data),  32'h1A);
      in_valid = 1'b0;
      tick();
      check("steer_b_popped", 32'(b_valid), 32'd0);

      // Backpressure on A, then a single-cycle pop
      a_ready = 1'b0; b_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h01;
      tick();
      check("bp_ready_one", 32'(in_ready), 32'd1);
      in_data = 8'h02;
      tick();
      check("bp_full_ready", 32'(in_ready), 32'd0);
      check("bp_head",       32'(a_data),   32'h01);
      in_data = 8'h03;          // offered while full, must be dropped
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0; in_valid = 1'b0;
      check("bp_ready_back", 32'(in_ready), 32'd1);
      check("bp_next_head",  32'(a_data),   32'h02);
      a_ready = 1'b1;
      tick();
      check("bp_no_extra", 32'(a_valid), 32'd0);

      // Pop on empty A must not underflow
      tick(); tick();
      a_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h44;
      tick();
      in_valid = 1'b0;
      check("underflow_valid", 32'(a_valid), 32'd1);
      check("underflow_data",  32'(a_data),  32'h44);
      tick();
      check("underflow_hold",  32'(a_data),  32'h44);
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      check("underflow_empty", 32'(a_valid), 32'd0);

      // Simultaneous push/pop on B
      in_valid = 1'b1; in_data = 8'h81;
      tick();
      check("pp_b_first", 32'(b_data), 32'h01);
      b_ready = 1'b1; in_data = 8'h85;
      tick();
      b_ready = 1'b0;
      check("pp_b_valid", 32'(b_valid),  32'd1);
      check("pp_b_data",  32'(b_data),   32'h05);
      check("pp_ready",   32'(in_ready), 32'd1);
      in_data = 8'h86;
      tick();
      in_valid = 1'b0;
      check("pp_count_full", 32'(in_ready), 32'd0);
      check("pp_b_head",     32'(b_data),   32'h05);

      // Flush with both FIFOs occupied
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      check("fl_b_head", 32'(b_data), 32'h06);
      in_valid = 1'b1; in_data = 8'h11;
      tick();
      check("fl_a_loaded", 32'(a_data), 32'h11);
      flush = 1'b1; in_data = 8'h33;
      #1;
      check("fl_ready_during", 32'(in_ready), 32'd1);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_a_valid", 32'(a_valid), 32'd0);
      check("fl_b_valid", 32'(b_valid), 32'd0);
      check("fl_a_data",  32'(a_data),  32'h0);
      tick();
      check("fl_33_absent", 32'(a_valid), 32'd0);

      // Mid-operation reset
      in_valid = 1'b1; in_data = 8'hA2;
      tick();
      in_valid = 1'b0;
      check("mr_b_valid", 32'(b_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_b_dropped", 32'(b_valid), 32'd0);
      check("mr_b_data",    32'(b_data),  32'h0);

`ifdef Q3_STATUS_CNT_EN
      // 300 tag-0 bytes with A draining every cycle
      a_ready = 1'b1; in_valid = 1'b1; in_data = 8'h07;
      for (int i = 0; i < 300; i++) tick();
      in_valid = 1'b0;
      check("cnt_a_sat", 32'(a_cnt), 32'd255);
      check("cnt_b_zero", 32'(b_cnt), 32'd0);
      in_valid = 1'b1; in_data = 8'h87;
      tick();
      in_valid = 1'b0;
      check("cnt_b_one", 32'(b_cnt), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("cnt_a_flush", 32'(a_cnt), 32'd0);
      check("cnt_b_flush", 32'(b_cnt), 32'd0);
      a_ready = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
